// File: rtl/bus_cycle_sequencer.sv
// Initiator side of the CPU status/command protocol: runs one 8088-style
// T1-T2-T3-[Tw]-T4 bus cycle per accepted request, with wait-state timeout.
module bus_cycle_sequencer #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int WAIT_LIMIT    = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_clock_posedge,
  input  logic                     cpu_clock_negedge,
  input  logic                     HLDA,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_io,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [7:0]               req_data,
  output logic                     resp_valid,
  output logic [7:0]               resp_data,
  output logic                     resp_timeout,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [7:0]               data_out,
  output logic                     data_oe,
  input  logic [7:0]               data_in,
  input  logic                     READY,
  output logic                     ALE,
  output logic                     RD_N,
  output logic                     WR_N,
  output logic                     IO_OR_M,
  output logic                     DT_OR_R,
  output logic                     DEN_N
);

  typedef enum logic [2:0] {IDLE, PEND, T1, T2, T3, TW, T4} state_e;

  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  state_e                   state_q;
  logic [7:0]               wait_cnt_q;
  logic                     write_q;
  logic                     io_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [7:0]               wdata_q;
  logic [7:0]               rdata_q;
  logic                     timeout_q;

  logic                     req_ready_q;
  logic                     resp_valid_q;
  logic [7:0]               resp_data_q;
  logic                     resp_timeout_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [7:0]               data_out_q;
  logic                     data_oe_q;
  logic                     ale_q;
  logic                     rd_n_q;
  logic                     wr_n_q;
  logic                     io_or_m_q;
  logic                     dt_or_r_q;
  logic                     den_n_q;

  // Posedge handling always takes priority: a coincident negedge pulse is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      write_q        <= 1'b0;
      io_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '1;
      timeout_q      <= 1'b0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '1;
      resp_timeout_q <= 1'b0;
      address_q      <= '0;
      data_out_q     <= '0;
      data_oe_q      <= 1'b0;
      ale_q          <= 1'b0;
      rd_n_q         <= 1'b1;
      wr_n_q         <= 1'b1;
      io_or_m_q      <= 1'b0;
      dt_or_r_q      <= 1'b1;
      den_n_q        <= 1'b1;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            write_q     <= req_write;
            io_q        <= req_io;
            addr_q      <= req_address;
            wdata_q     <= req_data;
            req_ready_q <= 1'b0;
            state_q     <= PEND;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        PEND: begin
          if (cpu_clock_posedge && !HLDA) begin
            state_q   <= T1;
            ale_q     <= 1'b1;
            address_q <= addr_q;
            io_or_m_q <= io_q;
            dt_or_r_q <= write_q;
            if (write_q) data_out_q <= wdata_q;
          end
        end
        T1: begin
          if (cpu_clock_posedge) begin
            state_q <= T2;
            ale_q   <= 1'b0;
            rd_n_q  <= write_q;
            wr_n_q  <= !write_q;
          end else if (cpu_clock_negedge) begin
            ale_q <= 1'b0;
            if (write_q) begin
              den_n_q   <= 1'b0;
              data_oe_q <= 1'b1;
            end
          end
        end
        T2: begin
          if (cpu_clock_posedge) begin
            state_q <= T3;
          end else if (cpu_clock_negedge && !write_q) begin
            den_n_q <= 1'b0;
          end
        end
        T3, TW: begin
          if (cpu_clock_posedge) begin
            if (READY) begin
              state_q   <= T4;
              rd_n_q    <= 1'b1;
              wr_n_q    <= 1'b1;
              rdata_q   <= write_q ? 8'hFF : data_in;
              timeout_q <= 1'b0;
            end else if (wait_cnt_q < WAIT_MAX) begin
              state_q    <= TW;
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end else begin
              state_q   <= T4;
              rd_n_q    <= 1'b1;
              wr_n_q    <= 1'b1;
              rdata_q   <= 8'hFF;
              timeout_q <= 1'b1;
            end
          end
        end
        T4: begin
          if (cpu_clock_posedge) begin
            state_q        <= IDLE;
            dt_or_r_q      <= 1'b1;
            io_or_m_q      <= 1'b0;
            den_n_q        <= 1'b1;
            data_oe_q      <= 1'b0;
            wait_cnt_q     <= '0;
            resp_valid_q   <= 1'b1;
            resp_data_q    <= rdata_q;
            resp_timeout_q <= timeout_q;
            req_ready_q    <= 1'b1;
          end else if (cpu_clock_negedge) begin
            den_n_q   <= 1'b1;
            data_oe_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_timeout = resp_timeout_q;
  assign address      = address_q;
  assign data_out     = data_out_q;
  assign data_oe      = data_oe_q;
  assign ALE          = ale_q;
  assign RD_N         = rd_n_q;
  assign WR_N         = wr_n_q;
  assign IO_OR_M      = io_or_m_q;
  assign DT_OR_R      = dt_or_r_q;
  assign DEN_N        = den_n_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: transaction-timeline model checked every cycle,
// plus literal expectations for each directed transfer.
module tb_bus_cycle_sequencer;
  localparam int AW = 20;
  localparam int WL = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_clock_posedge = 1'b0;
  logic          cpu_clock_negedge = 1'b0;
  logic          HLDA = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic          req_io = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [7:0]    req_data = '0;
  logic          resp_valid;
  logic [7:0]    resp_data;
  logic          resp_timeout;
  logic [AW-1:0] address;
  logic [7:0]    data_out;
  logic          data_oe;
  logic [7:0]    data_in = '0;
  logic          READY = 1'b1;
  logic          ALE, RD_N, WR_N, IO_OR_M, DT_OR_R, DEN_N;

  bus_cycle_sequencer #(.ADDRESS_WIDTH(AW), .WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset),
    .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
    .HLDA(HLDA), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_io(req_io), .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout),
    .address(address), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .READY(READY), .ALE(ALE), .RD_N(RD_N), .WR_N(WR_N), .IO_OR_M(IO_OR_M),
    .DT_OR_R(DT_OR_R), .DEN_N(DEN_N)
  );

  initial forever #5 clock = ~clock;

  // Model: a transfer is a timeline anchored at the T1-entry edge e1 and the
  // T4-entry edge e4; CPU clock is 4 system clocks (posedge pulse at edge%4==0).
  int edge_n = 0;
  bit busy = 0;
  int e1 = -1, e4 = -1;
  bit t_write, t_io, t_to;
  logic [AW-1:0] t_addr;
  logic [7:0] t_data, t_cap;
  int n_acc = 0, n_done = 0;
  bit inb, den_on;

  bit exp_ale = 0, exp_rd = 1, exp_wr = 1, exp_io = 0, exp_dt = 1, exp_den = 1, exp_oe = 0;
  bit exp_rv = 0, exp_to = 0, exp_ready = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0] exp_dout = '0, exp_rdata = 8'hFF;

  always @(posedge clock) begin
    edge_n++;
    exp_rv = 0;
    if (reset) begin
      busy = 0; e1 = -1; e4 = -1;
      exp_ready = 0; exp_addr = '0; exp_dout = '0; exp_rdata = 8'hFF; exp_to = 0;
    end else if (!busy) begin
      if (req_valid && exp_ready) begin
        busy = 1; n_acc++; e1 = -1; e4 = -1; exp_ready = 0;
        t_write = req_write; t_io = req_io; t_addr = req_address; t_data = req_data;
      end else begin
        exp_ready = 1;
      end
    end else if (e1 < 0) begin
      if (cpu_clock_posedge && !HLDA) begin
        e1 = edge_n;
        exp_addr = t_addr;
        if (t_write) exp_dout = t_data;
      end
    end else if (e4 < 0) begin
      if (cpu_clock_posedge && edge_n >= e1 + 12) begin
        if (READY) begin
          e4 = edge_n; t_cap = t_write ? 8'hFF : data_in; t_to = 0;
        end else if ((edge_n - e1 - 12) / 4 == WL) begin
          e4 = edge_n; t_cap = 8'hFF; t_to = 1;
        end
      end
    end else if (edge_n == e4 + 4) begin
      busy = 0; n_done++; exp_rv = 1; exp_rdata = t_cap; exp_to = t_to; exp_ready = 1;
    end
    inb = busy && (e1 >= 0);
    exp_ale = inb && (edge_n < e1 + 2);
    exp_io = inb && t_io;
    exp_dt = !(inb && !t_write);
    exp_rd = !(inb && !t_write && edge_n >= e1 + 4 && e4 < 0);
    exp_wr = !(inb && t_write && edge_n >= e1 + 4 && e4 < 0);
    den_on = inb && (edge_n >= (t_write ? e1 + 2 : e1 + 6)) && (e4 < 0 || edge_n < e4 + 2);
    exp_den = !den_on;
    exp_oe = den_on && t_write;
  end

  int n_checks = 0, n_fail = 0;
  int obs_rd, obs_wr, obs_ale, obs_oe, obs_rv, obs_t1, obs_rv_edge;
  int ready_lows = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (edge %0d)", nm, edge_n);
  endtask

  task automatic tick();
    @(negedge clock);
    chk("ALE", 32'(ALE), 32'(exp_ale));
    chk("RD_N", 32'(RD_N), 32'(exp_rd));
    chk("WR_N", 32'(WR_N), 32'(exp_wr));
    chk("IO_OR_M", 32'(IO_OR_M), 32'(exp_io));
    chk("DT_OR_R", 32'(DT_OR_R), 32'(exp_dt));
    chk("DEN_N", 32'(DEN_N), 32'(exp_den));
    chk("data_oe", 32'(data_oe), 32'(exp_oe));
    chk("address", 32'(address), 32'(exp_addr));
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    chk("resp_data", 32'(resp_data), 32'(exp_rdata));
    chk("resp_timeout", 32'(resp_timeout), 32'(exp_to));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (RD_N === 1'b0) obs_rd++;
    if (WR_N === 1'b0) obs_wr++;
    if (data_oe === 1'b1) obs_oe++;
    if (ALE === 1'b1) begin
      obs_ale++;
      if (obs_t1 < 0) obs_t1 = edge_n;
    end
    if (resp_valid === 1'b1) begin
      obs_rv++;
      obs_rv_edge = edge_n;
    end
    cpu_clock_posedge = ((edge_n + 1) % 4 == 0);
    cpu_clock_negedge = ((edge_n + 1) % 4 == 2);
    if (cpu_clock_posedge && busy && e1 >= 0 && edge_n + 1 >= e1 + 12 && ready_lows > 0) begin
      READY = 1'b0;
      ready_lows--;
    end else begin
      READY = 1'b1;
    end
  endtask

  task automatic run_txn(input bit w, input bit io, input logic [AW-1:0] a,
                         input logic [7:0] d, input logic [7:0] din, input int lows,
                         input int hlda_ticks, input int abort_at);
    int a0, d0, k;
    obs_rd = 0; obs_wr = 0; obs_ale = 0; obs_oe = 0; obs_rv = 0; obs_t1 = -1; obs_rv_edge = -1;
    ready_lows = lows; data_in = din;
    req_write = w; req_io = io; req_address = a; req_data = d; req_valid = 1'b1;
    a0 = n_acc; k = 0;
    while (n_acc == a0 && k < 50) begin tick(); k++; end
    req_valid = 1'b0;
    if (n_acc == a0) begin bound_fail("accept"); return; end
    if (hlda_ticks > 0) begin
      repeat (hlda_ticks) tick();
      HLDA = 1'b0;
    end
    k = 0;
    if (abort_at > 0) begin
      while (!(e1 >= 0 && edge_n >= e1 + abort_at) && k < 400) begin tick(); k++; end
      if (k >= 400) bound_fail("abort_point");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (4) tick();
    end else begin
      d0 = n_done;
      while (n_done == d0 && k < 400) begin tick(); k++; end
      if (n_done == d0) bound_fail("completion");
      repeat (2) tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    // memory read, no waits
    run_txn(0, 0, 20'hF0000, 8'h00, 8'h5A, 0, 0, 0);
    chk("t1_rd_low_cycles", 32'(obs_rd), 32'd8);
    chk("t1_ale_cycles", 32'(obs_ale), 32'd2);
    chk("t1_latency", 32'(obs_rv_edge - obs_t1), 32'd16);
    chk("t1_resp_data", 32'(resp_data), 32'h5A);
    chk("t1_resp_timeout", 32'(resp_timeout), 32'd0);
    chk("t1_resp_count", 32'(obs_rv), 32'd1);

    // I/O write
    run_txn(1, 1, 20'h00060, 8'hA5, 8'h00, 0, 0, 0);
    chk("t2_wr_low_cycles", 32'(obs_wr), 32'd8);
    chk("t2_oe_cycles", 32'(obs_oe), 32'd12);
    chk("t2_rd_low_cycles", 32'(obs_rd), 32'd0);
    chk("t2_data_out", 32'(data_out), 32'hA5);

    // read with three wait states
    run_txn(0, 0, 20'h12345, 8'h00, 8'hC3, 3, 0, 0);
    chk("t3_rd_low_cycles", 32'(obs_rd), 32'd20);
    chk("t3_resp_data", 32'(resp_data), 32'hC3);

    // READY stuck low -> timeout after WL waits
    run_txn(0, 1, 20'h00ABC, 8'h00, 8'h77, 100, 0, 0);
    chk("t4_rd_low_cycles", 32'(obs_rd), 32'd24);
    chk("t4_resp_timeout", 32'(resp_timeout), 32'd1);
    chk("t4_resp_data", 32'(resp_data), 32'hFF);

    // HLDA held for 5 CPU clocks after acceptance
    HLDA = 1'b1;
    run_txn(0, 0, 20'hABCDE, 8'h00, 8'h3C, 0, 20, 0);
    chk("t5_resp_data", 32'(resp_data), 32'h3C);
    chk("t5_ale_cycles", 32'(obs_ale), 32'd2);
    chk("t5_latency", 32'(obs_rv_edge - obs_t1), 32'd16);

    // reset during Tw, then a normal transfer
    run_txn(0, 0, 20'h55555, 8'h00, 8'h11, 100, 0, 20);
    chk("t6_abort_resp_count", 32'(obs_rv), 32'd0);
    chk("t6_abort_resp_data", 32'(resp_data), 32'hFF);
    run_txn(0, 0, 20'h0BEEF, 8'h00, 8'h96, 0, 0, 0);
    chk("t6_resp_data", 32'(resp_data), 32'h96);
    chk("t6_resp_count", 32'(obs_rv), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
- Initiator side of the CPU status/command protocol.
- Turns a single-transfer request from an internal master (DMA/test engine) into an 8088-style bus cycle T1–T2–T3–[Tw…]–T4.
- Drives RD_N, WR_N, IO_OR_M, DT_OR_R, DEN_N and ALE, the inputs the bus command decoder consumes.
- Samples READY, returns read data, and aborts stuck cycles on a wait-state timeout.

Parameters:
- ADDRESS_WIDTH, 20, width of req_address/address.
- WAIT_LIMIT, 255, max Tw states before forced termination (1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_clock_posedge  in  1  one-clock pulse at CPU clock rising edge (T-state boundary)
- cpu_clock_negedge  in  1  one-clock pulse at CPU clock falling edge (mid T-state)
- HLDA  in  1  hold acknowledge; blocks new cycle start
- req_valid  in  1  transfer request
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_io  in  1  1=I/O, 0=memory
- req_address  in  ADDRESS_WIDTH  transfer address
- req_data  in  8  write data
- resp_valid  out  1  one-clock completion pulse
- resp_data  out  8  read data (held until next completion)
- resp_timeout  out  1  completion was a timeout (valid with resp_valid)
- address  out  ADDRESS_WIDTH  latched bus address
- data_out  out  8  bus write data
- data_oe  out  1  write-data drive enable
- data_in  in  8  bus read data
- READY  in  1  bus ready; low inserts Tw
- ALE, RD_N, WR_N, IO_OR_M, DT_OR_R, DEN_N  out  1 each  bus status/command, 8088 polarity

Behaviour:
- Reset values:
  - ALE=0, RD_N=1, WR_N=1, IO_OR_M=0, DT_OR_R=1, DEN_N=1, data_oe=0.
  - address=0, data_out=0, resp_valid=0, resp_data=8'hFF, resp_timeout=0, req_ready=0.
  - State IDLE, wait counter 0.
- Reset mid-cycle returns every output to its reset value on the next clock. No resp_valid is issued for the aborted cycle.
- States: IDLE, PEND, T1, T2, T3, TW, T4. All T-state transitions occur only on clocks where cpu_clock_posedge=1.
- IDLE:
  - req_ready=1 (registered; 0 in every other state and during reset).
  - On valid&ready, latch write/io/address/data and go to PEND.
- PEND:
  - On cpu_clock_posedge with HLDA=0, go to T1.
  - With HLDA=1, stay in PEND; all bus outputs remain idle.
- T1:
  - address and IO_OR_M driven; ALE=1 from T1 entry until the first cpu_clock_negedge in T1.
  - DT_OR_R=0 for reads, from T1 entry until T4 exit.
  - Write: DEN_N=0 and data_oe=1 from T1 cpu_clock_negedge.
- T2:
  - RD_N or WR_N=0 from T2 entry.
  - Read: DEN_N=0 from T2 cpu_clock_negedge.
- T3 and TW, on cpu_clock_posedge:
  - READY=1: capture data_in (reads), go to T4.
  - READY=0 and wait counter < WAIT_LIMIT: go to TW, counter+1.
  - READY=0 and counter == WAIT_LIMIT: go to T4 with timeout flag set; read data forced to 8'hFF.
- T4:
  - RD_N/WR_N=1 at T4 entry.
  - DEN_N=1 and data_oe=0 at the T4 cpu_clock_negedge.
  - On the next cpu_clock_posedge: go to IDLE, DT_OR_R=1, IO_OR_M=0, counter cleared, resp_valid=1 for exactly that clock, resp_data/resp_timeout updated.
- HLDA only gates the PEND→T1 transition. A cycle already in T1 or later runs to completion.
- If cpu_clock_posedge and cpu_clock_negedge are asserted together, it is a protocol error: posedge processing applies, negedge is ignored.
- Latency with zero waits: PEND plus 4 CPU clocks to resp_valid.
- Only one outstanding request at a time; req_* inputs are ignored outside IDLE.

Test Plan:
1. Memory read at 20'hF0000, READY=1 throughout, data_in=8'h5A → ALE high only in first half of T1; RD_N low T2–T3; DT_OR_R low T1–T4; IO_OR_M=0; resp_valid 4 CPU clocks after T1 entry with resp_data=8'h5A, resp_timeout=0.
2. I/O write to 20'h00060 with data 8'hA5 → IO_OR_M=1, WR_N low T2–T3, DEN_N/data_oe asserted from T1 negedge to T4 negedge, data_out=8'hA5, DT_OR_R stays 1.
3. Read with READY low for 3 posedges → exactly 3 Tw states; RD_N stays low through them; data captured on the READY=1 posedge.
4. READY held low with WAIT_LIMIT=4 → 4 Tw states, then T4; resp_timeout=1, resp_data=8'hFF.
5. HLDA=1 when request accepted, released after 5 CPU clocks → stays in PEND, all bus outputs idle, req_ready=0; T1 starts on the first posedge with HLDA=0.
6. Reset asserted during TW → next clock all outputs at reset values, no resp_valid; a new request afterwards completes normally.
